imem_fetch_port: RTL and testbench
==================================

// Module: imem_fetch_port
// PURPOSE
//  Parametrised, clocked LEGv8 instruction memory with valid/ready fetch and
//  response handshakes, a LATENCY-stage read pipeline and a response FIFO.
//  Adds a word-write program-load port, flush and per-fetch fault flags.
//  Sits between the IF-stage PC logic and the IF/ID pipeline register.
// PARAMETERS
//  ADDR_W      64   width of fetch/program byte addresses
//  DEPTH_BYTES 512  byte capacity; multiple of 4, power of two
//  LATENCY     1    read pipeline stages (1..4); accept->response edges
// PORTS
//  clk        in   1       rising-edge clock
//  rst        in   1       synchronous, active-high reset
//  req_valid  in   1       fetch request present
//  req_ready  out  1       fetch request accepted when valid&ready
//  req_addr   in   ADDR_W  fetch byte address
//  rsp_valid  out  1       response at FIFO head
//  rsp_ready  in   1       consumer takes response when valid&ready
//  rsp_instr  out  32      instruction word, little-endian
//  rsp_fault  out  2       [0] misaligned, [1] out-of-range
//  prog_we    in   1       program-load word write
//  prog_addr  in   ADDR_W  write byte address; bits[1:0] ignored
//  prog_data  in   32      write data, little-endian
//  flush      in   1       discard all in-flight and buffered responses
// BEHAVIOUR
//  - Storage: byte array mem[0:DEPTH_BYTES-1], all zero at time 0; rst does
//    not alter contents. instr = {mem[a+3],mem[a+2],mem[a+1],mem[a]}.
//  - Reset (rst high at edge): pipeline and FIFO emptied, credit count 0,
//    rsp_valid=0, rsp_instr=0, rsp_fault=0; req_ready=0 while rst high.
//  - Faults: misaligned if req_addr[1:0]!=0; out-of-range if
//    req_addr > DEPTH_BYTES-4 (full ADDR_W compare, no wrap). Any fault ->
//    rsp_instr=0, flag(s) set; both may be set together. Faulted fetches
//    still occupy a slot and return in order.
//  - Pipeline: accepted fetch reads mem at accept edge, then shifts through
//    LATENCY-1 further registers every cycle (never stalls) into FIFO of
//    depth LATENCY+1. Empty FIFO: accept at edge T -> rsp_valid=1 after
//    edge T+LATENCY-1 (LATENCY=1: visible the cycle after accept).
//  - Ordering: responses strictly in request order; head held stable
//    (instr, fault) while rsp_valid & !rsp_ready.
//  - Credits: cnt = in-flight + FIFO entries, 0..LATENCY+1.
//    req_ready = !rst & !flush & (cnt < LATENCY+1). cnt +1 on accept, -1 on
//    pop; both same cycle -> unchanged. FIFO never overflows.
//  - Throughput: req_valid & rsp_ready held high -> one fetch per cycle.
//  - Program write: prog_we & !rst at edge writes 4 bytes at
//    {prog_addr[ADDR_W-1:2],2'b00}; ignored if that address > DEPTH_BYTES-4.
//    Fetch of the same word accepted at that edge reads OLD data
//    (read-before-write); fetches accepted later see new data.
//  - Flush at edge: pipeline/FIFO emptied, cnt=0, rsp_valid=0 next cycle;
//    no request accepted that cycle; prog writes still take effect.
//  - rst wins over flush; rst mid-burst drops all outstanding responses.
// TESTING
//  1 LATENCY=1: prog word 0x8b1f03e5 @0, fetch 0 -> rsp_valid next cycle,
//    instr 0x8b1f03e5, fault 00; mem[0..3]=e5,03,1f,8b.
//  2 LATENCY=3: fetch 0,4,8,12 back-to-back, rsp_ready=1 -> 4 in-order
//    responses in consecutive cycles, first 3 edges after first accept.
//  3 rsp_ready=0, LATENCY=2: accept exactly 3 fetches, req_ready=0 after;
//    release rsp_ready -> 3 responses in order, req_ready returns high.
//  4 fetch 0x6 -> fault 01, instr 0; fetch 0x1FE -> fault 11;
//    fetch 0x1FC -> fault 00; prog write to 0x200 -> mem unchanged.
//  5 same-edge prog_we 0xf84000a4 @4 and fetch 4 -> old word; next fetch 4
//    -> 0xf84000a4.
//  6 flush (then rst) with 3 outstanding -> rsp_valid=0 next cycle, no
//    stale response afterward, cnt=0; new fetch returns normally.

Source files
------------

// File: rtl/imem_fetch_port.sv
// imem_fetch_port: byte-addressed LEGv8 instruction memory with a fetch
// request/response handshake, a LATENCY-deep read pipeline and response FIFO.
//
// Ports:
//   clk, rst             rising-edge clock, synchronous active-high reset
//   req_valid/ready/addr fetch request handshake and byte address
//   rsp_valid/ready      response handshake at the FIFO head
//   rsp_instr, rsp_fault instruction word and {out-of-range, misaligned}
//   prog_we/addr/data    program-load word write
//   flush                drop every in-flight and buffered response
module imem_fetch_port #(
    parameter int ADDR_W      = 64,
    parameter int DEPTH_BYTES = 512,
    parameter int LATENCY     = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_instr,
    output logic [1:0]        rsp_fault,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [31:0]       prog_data,
    input  logic              flush
);

    localparam int FD   = LATENCY + 1;
    localparam int CW   = $clog2(FD + 1);
    localparam int PW   = $clog2(FD);
    localparam int MW   = $clog2(DEPTH_BYTES);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH_BYTES - 4);
    localparam logic [ADDR_W-1:0] WMSK = ~ADDR_W'(3);

    logic [7:0]    r_mem [DEPTH_BYTES];
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] r_fn;
    logic [PW-1:0] r_wp;
    logic [PW-1:0] r_rp;
    logic [31:0]   r_fi [FD];
    logic [1:0]    r_ff [FD];

    logic              w_acc;
    logic              w_pop;
    logic [1:0]        w_fault;
    logic [MW-1:0]     w_rb;
    logic [31:0]       w_rinstr;
    logic [ADDR_W-1:0] w_pa;
    logic [MW-1:0]     w_pb;
    logic              w_pok;
    logic              w_fin_v;
    logic [31:0]       w_fin_i;
    logic [1:0]        w_fin_f;

    assign req_ready = !rst && !flush && (r_cnt < CW'(FD));
    assign w_acc     = req_valid && req_ready;
    assign rsp_valid = (r_fn != '0);
    assign w_pop     = rsp_valid && rsp_ready;

    assign w_fault[0] = (req_addr[1:0] != 2'b00);
    assign w_fault[1] = (req_addr > LAST);

    // Word read from the aligned base; a faulted fetch returns zero instead.
    assign w_rb = req_addr[MW-1:0] & ~MW'(3);
    assign w_rinstr = (w_fault != 2'b00) ? 32'h0 :
        {r_mem[w_rb + MW'(3)], r_mem[w_rb + MW'(2)],
         r_mem[w_rb + MW'(1)], r_mem[w_rb]};

    assign w_pa  = prog_addr & WMSK;
    assign w_pb  = w_pa[MW-1:0];
    assign w_pok = (w_pa <= LAST);

    // The read above samples pre-write contents, so a same-edge fetch of
    // the written word sees the old value.
    always_ff @(posedge clk) begin
        if (!rst && prog_we && w_pok) begin
            r_mem[w_pb]          <= prog_data[7:0];
            r_mem[w_pb + MW'(1)] <= prog_data[15:8];
            r_mem[w_pb + MW'(2)] <= prog_data[23:16];
            r_mem[w_pb + MW'(3)] <= prog_data[31:24];
        end
    end

    generate
        if (LATENCY == 1) begin : g_direct
            assign w_fin_v = w_acc;
            assign w_fin_i = w_rinstr;
            assign w_fin_f = w_fault;
        end else begin : g_pipe
            logic        r_pv [LATENCY-1];
            logic [31:0] r_pi [LATENCY-1];
            logic [1:0]  r_pf [LATENCY-1];

            always_ff @(posedge clk) begin
                if (rst || flush) begin
                    for (int k = 0; k < LATENCY - 1; k++) begin
                        r_pv[k] <= 1'b0;
                    end
                end else begin
                    r_pv[0] <= w_acc;
                    for (int k = 1; k < LATENCY - 1; k++) begin
                        r_pv[k] <= r_pv[k-1];
                    end
                end
                r_pi[0] <= w_rinstr;
                r_pf[0] <= w_fault;
                for (int k = 1; k < LATENCY - 1; k++) begin
                    r_pi[k] <= r_pi[k-1];
                    r_pf[k] <= r_pf[k-1];
                end
            end

            assign w_fin_v = r_pv[LATENCY-2];
            assign w_fin_i = r_pi[LATENCY-2];
            assign w_fin_f = r_pf[LATENCY-2];
        end
    endgenerate

    // Credit count bounds in-flight plus buffered entries to the FIFO depth.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_cnt <= '0;
            r_fn  <= '0;
            r_wp  <= '0;
            r_rp  <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(w_acc) - CW'(w_pop);
            r_fn  <= r_fn + CW'(w_fin_v) - CW'(w_pop);
            if (w_fin_v) begin
                r_wp <= (r_wp == PW'(FD - 1)) ? '0 : r_wp + PW'(1);
            end
            if (w_pop) begin
                r_rp <= (r_rp == PW'(FD - 1)) ? '0 : r_rp + PW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_fin_v) begin
            r_fi[r_wp] <= w_fin_i;
            r_ff[r_wp] <= w_fin_f;
        end
    end

    assign rsp_instr = rsp_valid ? r_fi[r_rp] : 32'h0;
    assign rsp_fault = rsp_valid ? r_ff[r_rp] : 2'b00;

endmodule

// File: tb/tb_imem_fetch_port.sv
// tb_imem_fetch_port: four instances (LATENCY 1..4) on shared stimulus,
// each checked every cycle against a timed-queue reference model.
module tb_imem_fetch_port;

    localparam int NI = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic [63:0] req_addr = '0;
    logic        rsp_ready = 1'b0;
    logic        prog_we = 1'b0;
    logic [63:0] prog_addr = '0;
    logic [31:0] prog_data = '0;
    logic        flush = 1'b0;

    logic [NI-1:0] rr;
    logic [NI-1:0] rv;
    logic [31:0]   ri [NI];
    logic [1:0]    rf [NI];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        imem_fetch_port #(
            .ADDR_W(64), .DEPTH_BYTES(512), .LATENCY(g + 1)
        ) u_dut (
            .clk(clk), .rst(rst),
            .req_valid(req_valid), .req_ready(rr[g]), .req_addr(req_addr),
            .rsp_valid(rv[g]), .rsp_ready(rsp_ready),
            .rsp_instr(ri[g]), .rsp_fault(rf[g]),
            .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
            .flush(flush)
        );
    end

    // Reference: per instance, an ordered list of pending responses, each
    // tagged with the first edge count at which it becomes visible.
    logic [7:0]  mm [512];
    int          n  [NI];
    logic [31:0] qi [NI][8];
    logic [1:0]  qf [NI][8];
    int          qa [NI][8];
    int          edge_n = 0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] word_at(input int a);
        return {mm[a+3], mm[a+2], mm[a+1], mm[a]};
    endfunction

    task automatic model_edge();
        logic [1:0]  ft;
        logic [31:0] rd;
        logic [63:0] pa;
        bit acc;
        bit pop;
        int lat;
        edge_n++;
        ft = {req_addr > 64'd508, req_addr[1:0] != 2'b00};
        rd = (ft != 2'b00) ? 32'h0 : word_at(int'(req_addr[8:0]));
        for (int i = 0; i < NI; i++) begin
            lat = i + 1;
            if (rst || flush) begin
                n[i] = 0;
            end else begin
                acc = req_valid && (n[i] < lat + 1);
                pop = rsp_ready && n[i] > 0 && qa[i][0] <= edge_n - 1;
                if (pop) begin
                    for (int k = 0; k < 7; k++) begin
                        qi[i][k] = qi[i][k+1];
                        qf[i][k] = qf[i][k+1];
                        qa[i][k] = qa[i][k+1];
                    end
                    n[i]--;
                end
                if (acc) begin
                    qi[i][n[i]] = rd;
                    qf[i][n[i]] = ft;
                    qa[i][n[i]] = edge_n + lat - 1;
                    n[i]++;
                end
            end
        end
        if (prog_we && !rst) begin
            pa = prog_addr & ~64'd3;
            if (pa <= 64'd508) begin
                mm[int'(pa)]   = prog_data[7:0];
                mm[int'(pa)+1] = prog_data[15:8];
                mm[int'(pa)+2] = prog_data[23:16];
                mm[int'(pa)+3] = prog_data[31:24];
            end
        end
    endtask

    task automatic check_all();
        bit ev;
        for (int i = 0; i < NI; i++) begin
            ev = n[i] > 0 && qa[i][0] <= edge_n;
            chk($sformatf("L%0d_ready", i + 1), 64'(rr[i]),
                64'(!rst && !flush && n[i] < i + 2));
            chk($sformatf("L%0d_valid", i + 1), 64'(rv[i]), 64'(ev));
            if (ev) begin
                chk($sformatf("L%0d_instr", i + 1), 64'(ri[i]), 64'(qi[i][0]));
                chk($sformatf("L%0d_fault", i + 1), 64'(rf[i]), 64'(qf[i][0]));
            end
        end
    endtask

    task automatic cyc();
        model_edge();
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic idle(input int k);
        req_valid = 1'b0;
        prog_we = 1'b0;
        for (int j = 0; j < k; j++) cyc();
    endtask

    task automatic fetch1(input logic [63:0] a);
        req_valid = 1'b1;
        req_addr = a;
        cyc();
        req_valid = 1'b0;
    endtask

    function automatic logic [63:0] rand_addr();
        int r;
        r = int'($urandom % 16);
        if (r < 11) return 64'({$urandom_range(0, 127), 2'b00});
        if (r < 13) return 64'($urandom_range(0, 511));
        if (r < 15) return 64'($urandom_range(500, 520));
        return {$urandom, $urandom};
    endfunction

    logic [31:0] oldw;

    initial begin
        for (int a = 0; a < 512; a++) mm[a] = 8'h0;
        for (int i = 0; i < NI; i++) n[i] = 0;
        @(negedge clk);
        cyc();
        cyc();
        for (int i = 0; i < NI; i++) begin
            chk("rst_instr", 64'(ri[i]), 64'h0);
            chk("rst_fault", 64'(rf[i]), 64'h0);
        end
        chk("rst_valid", 64'(rv), 64'h0);
        chk("rst_ready", 64'(rr), 64'h0);
        rst = 1'b0;
        cyc();

        prog_we = 1'b1;
        for (int w = 0; w < 128; w++) begin
            prog_addr = 64'(w * 4);
            prog_data = $urandom;
            cyc();
        end
        prog_addr = 64'h0;
        prog_data = 32'h8b1f03e5;
        cyc();
        prog_we = 1'b0;

        rsp_ready = 1'b1;
        fetch1(64'h0);
        chk("t1_valid", 64'(rv[0]), 64'h1);
        chk("t1_instr", 64'(ri[0]), 64'h8b1f03e5);
        chk("t1_fault", 64'(rf[0]), 64'h0);
        idle(6);

        req_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            req_addr = 64'(k * 4);
            cyc();
        end
        idle(8);

        rsp_ready = 1'b0;
        req_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            req_addr = 64'(16 + k * 4);
            cyc();
        end
        chk("t3_full", 64'(rr[1]), 64'h0);
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        idle(10);
        chk("t3_ready_back", 64'(rr[1]), 64'h1);

        fetch1(64'h6);
        chk("t4_mis_fault", 64'(rf[0]), 64'h1);
        chk("t4_mis_instr", 64'(ri[0]), 64'h0);
        fetch1(64'h1FE);
        chk("t4_both_fault", 64'(rf[0]), 64'h3);
        fetch1(64'h1FC);
        chk("t4_last_fault", 64'(rf[0]), 64'h0);
        fetch1(64'hFFFF_FFFF_FFFF_FFFC);
        chk("t4_huge_fault", 64'(rf[0]), 64'h2);
        oldw = word_at(508);
        prog_we = 1'b1;
        prog_addr = 64'h200;
        prog_data = 32'hdeadbeef;
        cyc();
        prog_we = 1'b0;
        fetch1(64'h1FC);
        chk("t4_oob_write", 64'(ri[0]), 64'(oldw));
        idle(6);

        oldw = word_at(4);
        prog_we = 1'b1;
        prog_addr = 64'h4;
        prog_data = 32'hf84000a4;
        fetch1(64'h4);
        prog_we = 1'b0;
        chk("t5_old", 64'(ri[0]), 64'(oldw));
        fetch1(64'h4);
        chk("t5_new", 64'(ri[0]), 64'hf84000a4);
        idle(6);

        for (int p = 0; p < 2; p++) begin
            rsp_ready = 1'b0;
            req_valid = 1'b1;
            for (int k = 0; k < 3; k++) begin
                req_addr = 64'(k * 4);
                cyc();
            end
            if (p == 0) flush = 1'b1;
            else rst = 1'b1;
            cyc();
            flush = 1'b0;
            rst = 1'b0;
            req_valid = 1'b0;
            rsp_ready = 1'b1;
            cyc();
            chk("t6_dropped", 64'(rv), 64'h0);
            idle(6);
            fetch1(64'h8);
            chk("t6_new", 64'(ri[0]), 64'(word_at(8)));
            idle(6);
        end

        for (int c = 0; c < 4000; c++) begin
            req_valid = ($urandom % 4) != 0;
            req_addr  = rand_addr();
            rsp_ready = ($urandom % 3) != 0;
            prog_we   = ($urandom % 8) == 0;
            prog_addr = rand_addr();
            prog_data = $urandom;
            flush     = ($urandom % 60) == 0;
            rst       = ($urandom % 250) == 0;
            cyc();
        end
        rst = 1'b0;
        flush = 1'b0;
        rsp_ready = 1'b1;
        idle(8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
